// File: rtl/alu_iterativa_if.sv
// Bus between the ALU control decoder and the iterative execution stage.
// The decoder side drives requests and operands; the ALU side returns status and result.
interface alu_iterativa_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [3:0]       op_i;
    logic             branch_en_i;
    logic [2:0]       branch_ctrl_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             taken_o;
    logic             illegal_o;

    modport master (
        output start_i, op_i, branch_en_i, branch_ctrl_i, a_i, b_i,
        input  busy_o, done_o, result_o, zero_o, taken_o, illegal_o
    );

    modport slave (
        input  start_i, op_i, branch_en_i, branch_ctrl_i, a_i, b_i,
        output busy_o, done_o, result_o, zero_o, taken_o, illegal_o
    );
endinterface

// File: rtl/alu_iterativa.sv
// Execution stage: single-cycle logic/arithmetic ops and bit-serial shifts,
// producing a registered result with zero and branch-taken flags.
module alu_iterativa #(
    parameter int WIDTH = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    alu_iterativa_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_opnd;
    logic [SHW-1:0]   r_cnt;
    logic [3:0]       r_op;
    logic             r_br_en;
    logic [2:0]       r_br_ctrl;
    logic             r_fill;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_taken;
    logic             r_illegal;

    logic             w_accept;
    logic [SHW-1:0]   w_shamt;
    logic             w_start_shift;
    logic             w_fin;
    logic             w_load;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_res;
    logic             w_op_ok;
    logic             w_br_en;
    logic [2:0]       w_br_ctrl;
    logic [1:0]       w_br;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
        logic v;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR,
            OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA: v = 1'b1;
            default:                                 v = 1'b0;
        endcase
        return v;
    endfunction

    // Shifts only reach this path with a zero shift amount, so they pass A through.
    function automatic logic [WIDTH-1:0] alu_comb(input logic [3:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] v;
        case (op)
            OP_AND:  v = a & b;
            OP_OR:   v = a | b;
            OP_ADD:  v = a + b;
            OP_SUB:  v = a - b;
            OP_XOR:  v = a ^ b;
            OP_SLT:  v = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: v = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL, OP_SRL, OP_SRA: v = a;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Returns {illegal, taken} for the branch condition applied to a result.
    function automatic logic [1:0] br_eval(input logic             en,
                                           input logic [2:0]       ctrl,
                                           input logic [WIDTH-1:0] res);
        logic [1:0] v;
        v = 2'b00;
        if (en) begin
            case (ctrl)
                3'b000:         v[0] = (res == '0);
                3'b001:         v[0] = (res != '0);
                3'b100, 3'b110: v[0] = res[0];
                3'b101, 3'b111: v[0] = ~res[0];
                default:        v[1] = 1'b1;
            endcase
        end
        return v;
    endfunction

    assign w_accept      = bus.start_i && (r_state != S_SHIFT);
    assign w_shamt       = bus.b_i[SHW-1:0];
    assign w_start_shift = w_accept && is_shift(bus.op_i) && (w_shamt != '0);
    assign w_fin         = (r_state == S_SHIFT) && (r_cnt == SHW'(1));
    assign w_load        = (w_accept && !w_start_shift) || w_fin;

    always_comb begin
        case (r_op)
            OP_SLL:  w_shift_nxt = {r_opnd[WIDTH-2:0], 1'b0};
            OP_SRL:  w_shift_nxt = {1'b0, r_opnd[WIDTH-1:1]};
            default: w_shift_nxt = {r_fill, r_opnd[WIDTH-1:1]};
        endcase
    end

    // Result source: the last serial step while shifting, else the live inputs.
    always_comb begin
        if (r_state == S_SHIFT) begin
            w_res     = w_shift_nxt;
            w_op_ok   = 1'b1;
            w_br_en   = r_br_en;
            w_br_ctrl = r_br_ctrl;
        end else begin
            w_op_ok   = op_legal(bus.op_i);
            w_res     = w_op_ok ? alu_comb(bus.op_i, bus.a_i, bus.b_i) : '0;
            w_br_en   = bus.branch_en_i;
            w_br_ctrl = bus.branch_ctrl_i;
        end
        w_br = br_eval(w_br_en, w_br_ctrl, w_res);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_start_shift ? S_SHIFT : S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_fin) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt     <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (w_start_shift) begin
                r_cnt <= w_shamt;
            end else if (r_state == S_SHIFT) begin
                r_cnt <= r_cnt - SHW'(1);
            end
            if (w_load) begin
                r_result  <= w_res;
                r_zero    <= (w_res == '0);
                r_taken   <= w_op_ok && w_br[0];
                r_illegal <= !w_op_ok || w_br[1];
            end
        end
    end

    // Shift operand and captured instruction fields need no reset: unused outside SHIFT.
    always_ff @(posedge clk_i) begin
        if (w_start_shift) begin
            r_opnd    <= bus.a_i;
            r_op      <= bus.op_i;
            r_br_en   <= bus.branch_en_i;
            r_br_ctrl <= bus.branch_ctrl_i;
            r_fill    <= bus.a_i[WIDTH-1];
        end else if (r_state == S_SHIFT) begin
            r_opnd <= w_shift_nxt;
        end
    end

    assign bus.busy_o    = (r_state == S_SHIFT);
    assign bus.done_o    = (r_state == S_DONE);
    assign bus.result_o  = r_result;
    assign bus.zero_o    = r_zero;
    assign bus.taken_o   = r_taken;
    assign bus.illegal_o = r_illegal;
endmodule

// File: tb/tb_alu_iterativa.sv
// Directed and randomized checks of alu_iterativa against a behavioural model.
module tb_alu_iterativa;
    localparam int WIDTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    alu_iterativa_if #(.WIDTH(WIDTH)) bus ();

    alu_iterativa #(.WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: result from plain arithmetic, latency = shift amount for shifts.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic be, input logic [2:0] ctrl,
                                  output logic [31:0] r, output logic z, output logic t,
                                  output logic il, output int k);
        int sh;
        bit legal;
        sh    = int'(b[4:0]);
        legal = 1'b1;
        k     = 0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = a - b;
            4'd4:  r = a ^ b;
            4'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  r = (a < b) ? 32'd1 : 32'd0;
            4'd9:  begin r = a << sh; k = sh; end
            4'd10: begin r = a >> sh; k = sh; end
            4'd11: begin r = $unsigned($signed(a) >>> sh); k = sh; end
            default: begin r = 32'd0; legal = 1'b0; end
        endcase
        z  = (r == 32'd0);
        t  = 1'b0;
        il = !legal;
        if (be) begin
            case (ctrl)
                3'd0:       t = z;
                3'd1:       t = !z;
                3'd4, 3'd6: t = r[0];
                3'd5, 3'd7: t = !r[0];
                default:    il = 1'b1;
            endcase
        end
        if (!legal) t = 1'b0;
    endfunction

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic be, input logic [2:0] ctrl,
                          input bit hold_start);
        logic [31:0] er;
        logic        ez, et, ei;
        int          k, cyc, nbusy;
        bit          got;
        model(op, a, b, be, ctrl, er, ez, et, ei, k);
        bus.start_i       = 1'b1;
        bus.op_i          = op;
        bus.a_i           = a;
        bus.b_i           = b;
        bus.branch_en_i   = be;
        bus.branch_ctrl_i = ctrl;
        @(posedge clk); #1;
        bus.start_i       = hold_start;
        bus.op_i          = 4'($urandom);
        bus.a_i           = $urandom;
        bus.b_i           = $urandom;
        bus.branch_en_i   = 1'($urandom);
        bus.branch_ctrl_i = 3'($urandom);
        cyc   = 0;
        nbusy = 0;
        got   = 1'b0;
        while (!got && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (bus.done_o) begin
                got         = 1'b1;
                bus.start_i = 1'b0;
            end else if (bus.busy_o) begin
                nbusy++;
            end
        end
        check({tag, "_latency"}, cyc, k + 1);
        check({tag, "_busycycles"}, nbusy, k);
        check({tag, "_busy_at_done"}, bus.busy_o, 1'b0);
        check({tag, "_result"}, bus.result_o, er);
        check({tag, "_zero"}, bus.zero_o, ez);
        check({tag, "_taken"}, bus.taken_o, et);
        check({tag, "_illegal"}, bus.illegal_o, ei);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done_o, 1'b0);
        check({tag, "_hold"}, bus.result_o, er);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [14];
        int         nd;
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd10, 4'd11,
                4'd7, 4'd8, 4'd12, 4'd15};
        bus.start_i       = 1'b0;
        bus.op_i          = 4'd0;
        bus.branch_en_i   = 1'b0;
        bus.branch_ctrl_i = 3'd0;
        bus.a_i           = '0;
        bus.b_i           = '0;
        rst_n             = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_done", bus.done_o, 1'b0);
        check("rst_result", bus.result_o, 32'd0);
        check("rst_zero", bus.zero_o, 1'b0);
        check("rst_taken", bus.taken_o, 1'b0);
        check("rst_illegal", bus.illegal_o, 1'b0);

        // Reset wins over a simultaneous start.
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.op_i    = 4'd2;
        bus.a_i     = 32'd5;
        bus.b_i     = 32'd6;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("rst_prio_done", bus.done_o, 1'b0);
        check("rst_prio_result", bus.result_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 3'd0, 1'b0);
        check("add_wrap_val", bus.result_o, 32'd0);
        run_op("sra4", 4'd11, 32'h8000_0000, 32'd4, 1'b0, 3'd0, 1'b0);
        check("sra4_val", bus.result_o, 32'hF800_0000);
        run_op("sra0", 4'd11, 32'h8000_0000, 32'd0, 1'b0, 3'd0, 1'b0);
        check("sra0_val", bus.result_o, 32'h8000_0000);
        run_op("blt", 4'd5, 32'hFFFF_FFFD, 32'd2, 1'b1, 3'b100, 1'b0);
        check("blt_taken_val", bus.taken_o, 1'b1);
        run_op("bgeu", 4'd6, 32'hFFFF_FFFD, 32'd2, 1'b1, 3'b111, 1'b0);
        check("bgeu_taken_val", bus.taken_o, 1'b1);
        run_op("illegal_op", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 3'd0, 1'b0);
        check("illegal_op_val", bus.illegal_o, 1'b1);
        run_op("beq_badctrl", 4'd4, 32'd7, 32'd7, 1'b1, 3'b010, 1'b0);
        check("beq_badctrl_val", bus.illegal_o, 1'b1);
        run_op("sll3_held", 4'd9, 32'h0000_0011, 32'd3, 1'b0, 3'd0, 1'b1);
        check("sll3_held_val", bus.result_o, 32'h0000_0088);

        // Back-to-back single-cycle ops: OR, XOR, SUB.
        bus.branch_en_i = 1'b0;
        bus.start_i     = 1'b1;
        bus.op_i        = 4'd1;
        bus.a_i         = 32'h0F0F_0000;
        bus.b_i         = 32'h0000_00F0;
        @(posedge clk); #1;
        bus.op_i = 4'd4;
        bus.a_i  = 32'hFFFF_0000;
        bus.b_i  = 32'h0F0F_0F0F;
        @(negedge clk);
        check("b2b_or_done", bus.done_o, 1'b1);
        check("b2b_or_result", bus.result_o, 32'h0F0F_00F0);
        @(posedge clk); #1;
        bus.op_i = 4'd3;
        bus.a_i  = 32'd5;
        bus.b_i  = 32'd7;
        @(negedge clk);
        check("b2b_xor_done", bus.done_o, 1'b1);
        check("b2b_xor_result", bus.result_o, 32'hF0F0_0F0F);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("b2b_sub_done", bus.done_o, 1'b1);
        check("b2b_sub_result", bus.result_o, 32'hFFFF_FFFE);
        @(negedge clk);
        check("b2b_end_done", bus.done_o, 1'b0);
        @(posedge clk); #1;

        // Reset in the middle of a 20-step SRL.
        bus.start_i = 1'b1;
        bus.op_i    = 4'd10;
        bus.a_i     = 32'hDEAD_BEEF;
        bus.b_i     = 32'd20;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midrst_busy_before", bus.busy_o, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_busy", bus.busy_o, 1'b0);
        check("midrst_result", bus.result_o, 32'd0);
        check("midrst_done", bus.done_o, 1'b0);
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done_o) nd++;
        end
        check("midrst_no_done", nd, 0);
        @(posedge clk); #1;
        run_op("add_after_rst", 4'd2, 32'd100, 32'd23, 1'b0, 3'd0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            logic [3:0]  rop;
            ra  = $urandom;
            rb  = $urandom;
            rop = ops[$urandom_range(13, 0)];
            if (i % 4 == 0) rb = ra;
            if (i % 5 == 0) rb[4:0] = 5'd0;
            run_op($sformatf("rnd%0d", i), rop, ra, rb, 1'($urandom), 3'($urandom),
                   1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
